// File: rtl/add_pipe.sv
// Pipelined add/sub/accumulate unit with optional saturation, carry/overflow flags
// and valid/ready flow control; arithmetic resolves in stage 1, later stages only delay.
module add_pipe #(
    parameter int WIDTH    = 16,
    parameter int STAGES   = 2,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e              w_op;
    logic             w_take;
    logic             w_sub;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_res;
    logic             w_cry;
    logic             w_ovf;
    logic [STAGES-1:0] w_adv;

    logic [WIDTH-1:0]  r_acc;
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cry;
    logic [STAGES-1:0] r_ovf;
    logic [WIDTH-1:0]  r_res [STAGES];

    assign w_op     = op_e'(op);
    assign in_ready = w_adv[0];
    assign w_take   = in_valid && w_adv[0];

    always_comb begin
        w_a    = (w_op == OP_ACC) ? r_acc : in1;
        w_b    = (w_op == OP_ACC) ? in1 : in2;
        w_sub  = (w_op == OP_SUB);
        w_wide = w_sub ? ({1'b0, w_a} - {1'b0, w_b}) : ({1'b0, w_a} + {1'b0, w_b});
        w_cry  = w_wide[WIDTH];
        if (SIGNED != 0) begin
            w_ovf = (w_sub ? (w_a[WIDTH-1] != w_b[WIDTH-1]) : (w_a[WIDTH-1] == w_b[WIDTH-1]))
                    && (w_wide[WIDTH-1] != w_a[WIDTH-1]);
            // Overflow direction always follows the sign of the first operand.
            w_sat = w_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_ovf = w_cry;
            w_sat = w_sub ? '0 : '1;
        end
        w_res = ((SATURATE != 0) && w_ovf) ? w_sat : w_wide[WIDTH-1:0];
        if (w_op == OP_CLR) begin
            w_res = '0;
            w_cry = 1'b0;
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_take && ((w_op == OP_ACC) || (w_op == OP_CLR))) begin
            r_acc <= w_res;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stage moves when any stage at or beyond it has a hole, or the sink accepts.
        assign w_adv[k] = out_ready || !(&r_vld[STAGES-1:k]);

        if (k == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[0] <= 1'b0;
                    r_res[0] <= '0;
                    r_cry[0] <= 1'b0;
                    r_ovf[0] <= 1'b0;
                end else if (w_adv[0]) begin
                    r_vld[0] <= w_take;
                    if (w_take) begin
                        r_res[0] <= w_res;
                        r_cry[0] <= w_cry;
                        r_ovf[0] <= w_ovf;
                    end
                end
            end
        end else begin : g_delay
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[k] <= 1'b0;
                    r_res[k] <= '0;
                    r_cry[k] <= 1'b0;
                    r_ovf[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    r_res[k] <= r_res[k-1];
                    r_cry[k] <= r_cry[k-1];
                    r_ovf[k] <= r_ovf[k-1];
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out       = r_res[STAGES-1];
    assign carry     = r_cry[STAGES-1];
    assign ovf       = r_ovf[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: four parameterisations share one stimulus bus,
// each scenario task checks the instance it targets against hand-computed values.
module tb_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        out_ready;

    logic        u0_in_ready, u0_out_valid, u0_carry, u0_ovf;
    logic [15:0] u0_out;
    logic        u1_in_ready, u1_out_valid, u1_carry, u1_ovf;
    logic [15:0] u1_out;
    logic        u2_in_ready, u2_out_valid, u2_carry, u2_ovf;
    logic [15:0] u2_out;
    logic        u3_in_ready, u3_out_valid, u3_carry, u3_ovf;
    logic [15:0] u3_out;

    int chk_n  = 0;
    int pass_n = 0;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(0), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u0_in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(u0_out_valid), .out_ready(out_ready),
        .out(u0_out), .carry(u0_carry), .ovf(u0_ovf));

    add_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(0), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u1_in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(u1_out_valid), .out_ready(out_ready),
        .out(u1_out), .carry(u1_carry), .ovf(u1_ovf));

    add_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(1), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(u2_out_valid), .out_ready(out_ready),
        .out(u2_out), .carry(u2_carry), .ovf(u2_ovf));

    add_pipe #(.WIDTH(16), .STAGES(3), .SIGNED(0), .SATURATE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u3_in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(u3_out_valid), .out_ready(out_ready),
        .out(u3_out), .carry(u3_carry), .ovf(u3_ovf));

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_n++; if (u0_out_valid !== 1'b0) $display("FAIL rst_u0_valid: got %b exp 0", u0_out_valid); else pass_n++;
        chk_n++; if (u0_out !== 16'h0000) $display("FAIL rst_u0_out: got %h exp 0000", u0_out); else pass_n++;
        chk_n++; if ({u0_carry, u0_ovf} !== 2'b00) $display("FAIL rst_u0_flags: got %b exp 00", {u0_carry, u0_ovf}); else pass_n++;
        chk_n++; if (u3_out_valid !== 1'b0) $display("FAIL rst_u3_valid: got %b exp 0", u3_out_valid); else pass_n++;
        rst_n = 1'b1;
        #1;
        chk_n++; if (u0_in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", u0_in_ready); else pass_n++;
        cycle();
        chk_n++; if (u2_out_valid !== 1'b0) $display("FAIL rst_idle_valid: got %b exp 0", u2_out_valid); else pass_n++;
    endtask

    task automatic test_add_unsigned();
        drain();
        in_valid = 1'b1; op = 2'b00; in1 = 16'hFFFF; in2 = 16'h0001;
        cycle();
        in_valid = 1'b0;
        chk_n++; if (u0_out_valid !== 1'b0) $display("FAIL add_latency_early: got %b exp 0", u0_out_valid); else pass_n++;
        cycle();
        chk_n++; if (u0_out_valid !== 1'b1) $display("FAIL add_valid: got %b exp 1", u0_out_valid); else pass_n++;
        chk_n++; if (u0_out !== 16'h0000) $display("FAIL add_wrap_out: got %h exp 0000", u0_out); else pass_n++;
        chk_n++; if ({u0_carry, u0_ovf} !== 2'b11) $display("FAIL add_wrap_flags: got %b exp 11", {u0_carry, u0_ovf}); else pass_n++;
        chk_n++; if (u1_out !== 16'hFFFF) $display("FAIL add_sat_out: got %h exp ffff", u1_out); else pass_n++;
        chk_n++; if ({u1_carry, u1_ovf} !== 2'b11) $display("FAIL add_sat_flags: got %b exp 11", {u1_carry, u1_ovf}); else pass_n++;
        chk_n++; if (u2_out !== 16'h0000) $display("FAIL add_signed_out: got %h exp 0000", u2_out); else pass_n++;
        chk_n++; if ({u2_carry, u2_ovf} !== 2'b10) $display("FAIL add_signed_flags: got %b exp 10", {u2_carry, u2_ovf}); else pass_n++;
        cycle();
        chk_n++; if (u0_out_valid !== 1'b0) $display("FAIL add_consumed: got %b exp 0", u0_out_valid); else pass_n++;
    endtask

    task automatic test_signed_sat();
        drain();
        in_valid = 1'b1; op = 2'b01; in1 = 16'h8000; in2 = 16'h0001;
        cycle();
        op = 2'b00; in1 = 16'h7FFF; in2 = 16'h0001;
        cycle();
        in_valid = 1'b0;
        chk_n++; if (u2_out !== 16'h8000) $display("FAIL ssub_out: got %h exp 8000", u2_out); else pass_n++;
        chk_n++; if ({u2_carry, u2_ovf} !== 2'b01) $display("FAIL ssub_flags: got %b exp 01", {u2_carry, u2_ovf}); else pass_n++;
        chk_n++; if (u0_out !== 16'h7FFF) $display("FAIL usub_out: got %h exp 7fff", u0_out); else pass_n++;
        chk_n++; if ({u0_carry, u0_ovf} !== 2'b00) $display("FAIL usub_flags: got %b exp 00", {u0_carry, u0_ovf}); else pass_n++;
        cycle();
        chk_n++; if (u2_out !== 16'h7FFF) $display("FAIL sadd_out: got %h exp 7fff", u2_out); else pass_n++;
        chk_n++; if ({u2_carry, u2_ovf} !== 2'b01) $display("FAIL sadd_flags: got %b exp 01", {u2_carry, u2_ovf}); else pass_n++;
        chk_n++; if (u0_out !== 16'h8000) $display("FAIL uadd_out: got %h exp 8000", u0_out); else pass_n++;

        // Unsigned borrow with saturation clamps to zero.
        in_valid = 1'b1; op = 2'b01; in1 = 16'h0003; in2 = 16'h0005;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_n++; if (u1_out !== 16'h0000) $display("FAIL usub_sat_out: got %h exp 0000", u1_out); else pass_n++;
        chk_n++; if ({u1_carry, u1_ovf} !== 2'b11) $display("FAIL usub_sat_flags: got %b exp 11", {u1_carry, u1_ovf}); else pass_n++;
        chk_n++; if (u0_out !== 16'hFFFE) $display("FAIL usub_wrap_out: got %h exp fffe", u0_out); else pass_n++;
    endtask

    task automatic test_accumulate();
        logic [1:0]  ops  [6];
        logic [15:0] a    [6];
        logic [15:0] b    [6];
        logic [15:0] exp_o[6];
        ops = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        a   = '{16'd99, 16'd5, 16'd7, 16'd9, 16'd3, 16'd0};
        b   = '{16'hFFFF, 16'd50, 16'd50, 16'd50, 16'd4, 16'd50};
        exp_o = '{16'd0, 16'd5, 16'd12, 16'd21, 16'd7, 16'd21};
        drain();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                in_valid = 1'b1; op = ops[i]; in1 = a[i]; in2 = b[i];
                #1;
                chk_n++; if (u0_in_ready !== 1'b1) $display("FAIL acc_in_ready[%0d]: got %b exp 1", i, u0_in_ready); else pass_n++;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (i >= 1) begin
                chk_n++;
                if (u0_out_valid !== 1'b1 || u0_out !== exp_o[i-1])
                    $display("FAIL acc_out[%0d]: got v=%b %0d exp v=1 %0d", i - 1, u0_out_valid, u0_out, exp_o[i-1]);
                else pass_n++;
            end
            if (i == 1) begin
                chk_n++; if ({u0_carry, u0_ovf} !== 2'b00) $display("FAIL clr_flags: got %b exp 00", {u0_carry, u0_ovf}); else pass_n++;
            end
        end
    endtask

    task automatic test_stream();
        drain();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; op = 2'b00; in1 = 16'(i * 3); in2 = 16'd100;
                #1;
                chk_n++; if (u3_in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b exp 1", i, u3_in_ready); else pass_n++;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (i >= 2) begin
                chk_n++;
                if (u3_out_valid !== 1'b1 || u3_out !== 16'((i - 2) * 3 + 100))
                    $display("FAIL stream_out[%0d]: got v=%b %0d exp v=1 %0d", i - 2, u3_out_valid, u3_out, (i - 2) * 3 + 100);
                else pass_n++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          idx;
        int          got;
        logic        held;
        logic        stall_seen;
        logic [15:0] held_val;
        idx = 0; got = 0; held = 1'b0; stall_seen = 1'b0; held_val = '0;
        drain();
        for (int c = 0; c < 40 && got < 10; c++) begin
            in_valid  = (idx < 10);
            op        = 2'b00;
            in1       = 16'(idx);
            in2       = 16'd1000;
            out_ready = !(c >= 4 && c < 9);
            #1;
            if (held) begin
                chk_n++; if (u3_out !== held_val) $display("FAIL bp_stable[%0d]: got %0d exp %0d", c, u3_out, held_val); else pass_n++;
            end
            if (c == 9) begin
                chk_n++; if (u3_in_ready !== 1'b1) $display("FAIL bp_ready_resume: got %b exp 1", u3_in_ready); else pass_n++;
            end
            if (in_valid && !u3_in_ready && !stall_seen) begin
                stall_seen = 1'b1;
                chk_n++; if (idx - got !== 3) $display("FAIL bp_in_flight: got %0d exp 3", idx - got); else pass_n++;
            end
            if (u3_out_valid && out_ready) begin
                chk_n++; if (u3_out !== 16'(got + 1000)) $display("FAIL bp_order[%0d]: got %0d exp %0d", got, u3_out, got + 1000); else pass_n++;
                got++;
            end
            held     = u3_out_valid && !out_ready;
            held_val = u3_out;
            if (in_valid && u3_in_ready) idx++;
            cycle();
        end
        chk_n++; if (stall_seen !== 1'b1) $display("FAIL bp_stall_seen: got %b exp 1", stall_seen); else pass_n++;
        chk_n++; if (got !== 10) $display("FAIL bp_delivered: got %0d exp 10", got); else pass_n++;
        chk_n++; if (idx !== 10) $display("FAIL bp_accepted: got %0d exp 10", idx); else pass_n++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk_n++; if (u3_out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b exp 0", u3_out_valid); else pass_n++;
    endtask

    task automatic test_reset_mid();
        logic [1:0]  ops [4];
        logic [15:0] a   [4];
        ops = '{2'b11, 2'b10, 2'b10, 2'b10};
        a   = '{16'd0, 16'd5, 16'd7, 16'd9};
        drain();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = ops[i]; in1 = a[i]; in2 = 16'd0;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_n++; if (u0_out_valid !== 1'b1 || u0_out !== 16'd12) $display("FAIL rmid_inflight: got v=%b %0d exp v=1 12", u0_out_valid, u0_out); else pass_n++;
        rst_n = 1'b0;
        #1;
        chk_n++; if (u0_out_valid !== 1'b0) $display("FAIL rmid_valid: got %b exp 0", u0_out_valid); else pass_n++;
        chk_n++; if (u0_out !== 16'h0000) $display("FAIL rmid_out: got %h exp 0000", u0_out); else pass_n++;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_n++; if (u0_out_valid !== 1'b0) $display("FAIL rmid_spurious[%0d]: got %b exp 0", i, u0_out_valid); else pass_n++;
        end
        in_valid = 1'b1; op = 2'b10; in1 = 16'd1; in2 = 16'd0;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_n++; if (u0_out_valid !== 1'b1 || u0_out !== 16'd1) $display("FAIL rmid_acc: got v=%b %0d exp v=1 1", u0_out_valid, u0_out); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_add_unsigned();
        test_signed_sat();
        test_accumulate();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
